// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU MEM stage (port 0)
// and a secondary master (port 1); every output is driven straight from a register.
module dmem_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_ready,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    grant,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   state_t        state_q, state_d;
   logic          lastGrant_q, lastGrant_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [1:0]    grant_q, grant_d;
   logic          memWe_q, memWe_d;
   logic [AW-1:0] memAddr_q, memAddr_d;
   logic [DW-1:0] memWdata_q, memWdata_d;
   logic [DW-1:0] p0Rdata_q, p0Rdata_d;
   logic [DW-1:0] p1Rdata_q, p1Rdata_d;
   logic          p0Ready_q, p0Ready_d;
   logic          p1Ready_q, p1Ready_d;
   logic          busy_q, busy_d;
   logic          winner;

   // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      grant_d     = grant_q;
      memWe_d     = 1'b0;
      memAddr_d   = memAddr_q;
      memWdata_d  = memWdata_q;
      p0Rdata_d   = p0Rdata_q;
      p1Rdata_d   = p1Rdata_q;
      p0Ready_d   = 1'b0;
      p1Ready_d   = 1'b0;
      busy_d      = busy_q;
      winner      = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = 2'b00;
            busy_d  = 1'b0;
            if (p0_req || p1_req) begin
               // On a tie the port that did not win last time goes first.
               winner     = (p0_req && p1_req) ? ~lastGrant_q : p1_req;
               we_d       = winner ? p1_we    : p0_we;
               memAddr_d  = winner ? p1_addr  : p0_addr;
               memWdata_d = winner ? p1_wdata : p0_wdata;
               memWe_d    = we_d;
               grant_d    = winner ? 2'b10 : 2'b01;
               cnt_d      = 2'd0;
               busy_d     = 1'b1;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q) begin
               p0Ready_d = grant_q[0];
               p1Ready_d = grant_q[1];
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == LAST_CNT) begin
                  if (grant_q[1]) p1Rdata_d = mem_rdata;
                  else            p0Rdata_d = mem_rdata;
                  p0Ready_d = grant_q[0];
                  p1Ready_d = grant_q[1];
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            lastGrant_d = grant_q[1];
            grant_d     = 2'b00;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset abandons any transaction in flight; last grant starts at port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         cnt_q       <= 2'd0;
         we_q        <= 1'b0;
         grant_q     <= 2'b00;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         p0Rdata_q   <= '0;
         p1Rdata_q   <= '0;
         p0Ready_q   <= 1'b0;
         p1Ready_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         grant_q     <= grant_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         p0Rdata_q   <= p0Rdata_d;
         p1Rdata_q   <= p1Rdata_d;
         p0Ready_q   <= p0Ready_d;
         p1Ready_q   <= p1Ready_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign p0_rdata  = p0Rdata_q;
   assign p1_rdata  = p1Rdata_q;
   assign p0_ready  = p0Ready_q;
   assign p1_ready  = p1Ready_q;
   assign grant     = grant_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 1, 2, 3) share one stimulus stream, each with its own
// combinational-read memory; directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0Req, p0We, p1Req, p1We;
   logic [31:0] p0Addr, p0Wdata, p1Addr, p1Wdata;
   logic        preWe;
   logic [5:0]  preAddr;
   logic [31:0] preData;

   logic [31:0] p0RdataA [NI];
   logic [31:0] p1RdataA [NI];
   logic [31:0] memAddrA [NI];
   logic [31:0] memWdataA[NI];
   logic [31:0] memRdataA[NI];
   logic        p0ReadyA [NI];
   logic        p1ReadyA [NI];
   logic        memWeA   [NI];
   logic        busyA    [NI];
   logic [1:0]  grantA   [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance k runs with RD_LAT = k+1; memory words are indexed by the low six address bits.
   for (genvar k = 0; k < NI; k++) begin : gDut
      logic [31:0] memModel [64];

      dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(k + 1)) dut (
         .clk       (clk),
         .reset     (reset),
         .p0_req    (p0Req),
         .p0_we     (p0We),
         .p0_addr   (p0Addr),
         .p0_wdata  (p0Wdata),
         .p0_rdata  (p0RdataA[k]),
         .p0_ready  (p0ReadyA[k]),
         .p1_req    (p1Req),
         .p1_we     (p1We),
         .p1_addr   (p1Addr),
         .p1_wdata  (p1Wdata),
         .p1_rdata  (p1RdataA[k]),
         .p1_ready  (p1ReadyA[k]),
         .mem_we    (memWeA[k]),
         .mem_addr  (memAddrA[k]),
         .mem_wdata (memWdataA[k]),
         .mem_rdata (memRdataA[k]),
         .grant     (grantA[k]),
         .busy      (busyA[k])
      );

      assign memRdataA[k] = memModel[memAddrA[k][5:0]];

      always @(posedge clk) begin
         if (preWe)          memModel[preAddr] <= preData;
         else if (memWeA[k]) memModel[memAddrA[k][5:0]] <= memWdataA[k];
      end
   end

   // Packs the control outputs of one instance as {mem_we, grant, p0_ready, p1_ready, busy}.
   function automatic logic [5:0] status(input int k);
      return {memWeA[k], grantA[k], p0ReadyA[k], p1ReadyA[k], busyA[k]};
   endfunction

   task automatic applyStimulus(input bit port, input bit req, input bit we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1Req = req; p1We = we; p1Addr = addr; p1Wdata = wdata;
      end else begin
         p0Req = req; p0We = we; p0Addr = addr; p0Wdata = wdata;
      end
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      preWe = 1'b1; preAddr = a; preData = d;
      @(negedge clk);
      preWe = 1'b0;
   endtask

   // Returns at a negedge with reset released; the caller's stimulus then lands in cycle 0.
   task automatic doReset();
      idleInputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [133:0] v;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
         applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            v = {p0RdataA[k], p1RdataA[k], memAddrA[k], memWdataA[k],
                 p0ReadyA[k], p1ReadyA[k], memWeA[k], grantA[k], busyA[k]};
            checks++;
            if (v !== '0) begin
               errors++;
               $display("[TB] FAIL reset_outputs inst%0d cyc%0d: got %h, expected 0", k, c, v);
            end
         end
      end
      idleInputs();
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_p0();
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if ({status(0), memAddrA[0], memWdataA[0]} !== {6'b1_01_001, 32'h10, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL write_c1: got %b/%h/%h, expected 101001/10/deadbeef",
                  status(0), memAddrA[0], memWdataA[0]);
      end
      @(negedge clk);
      checks++;
      if (status(0) !== 6'b0_01_101) begin
         errors++;
         $display("[TB] FAIL write_c2_ready: got %b, expected 001101", status(0));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({status(0), p0RdataA[0]} !== {6'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL write_c3_idle: got %b/%h, expected 000000/0", status(0), p0RdataA[0]);
      end
      checks++;
      if (gDut[0].memModel[16] !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL write_mem_word: got %h, expected deadbeef", gDut[0].memModel[16]);
      end
   endtask

   task automatic test_read_p1();
      preload(6'h20, 32'h00001234);
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if ({status(1), memAddrA[1]} !== {6'b0_10_001, 32'h20}) begin
            errors++;
            $display("[TB] FAIL read_access_c%0d: got %b/%h, expected 010001/20", c, status(1), memAddrA[1]);
         end
      end
      @(negedge clk);
      checks++;
      if ({status(1), p1RdataA[1], p0RdataA[1]} !== {6'b0_10_011, 32'h1234, 32'h0}) begin
         errors++;
         $display("[TB] FAIL read_c3_ready: got %b/%h/%h, expected 010011/1234/0",
                  status(1), p1RdataA[1], p0RdataA[1]);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({status(1), p1RdataA[1]} !== {6'b0, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL read_retain: got %b/%h, expected 000000/1234", status(1), p1RdataA[1]);
      end
   endtask

   task automatic test_fairness();
      int ph, own;
      logic [5:0] exp;
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h04, 32'hA0A0A0A0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h08, 32'hB1B1B1B1);
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         // A write takes 3 cycles: ACCESS at t%3==1, DONE at t%3==2, IDLE at t%3==0.
         ph  = t % 3;
         own = (t / 3) % 2;
         exp = {ph == 1, (ph == 0) ? 2'b00 : (own != 0 ? 2'b10 : 2'b01),
                ph == 2 && own == 0, ph == 2 && own == 1, ph != 0};
         checks++;
         if (status(0) !== exp) begin
            errors++;
            $display("[TB] FAIL fair_t%0d: got %b, expected %b", t, status(0), exp);
         end
         if (ph == 1) begin
            checks++;
            if (memAddrA[0] !== (own != 0 ? 32'h08 : 32'h04)) begin
               errors++;
               $display("[TB] FAIL fair_addr_t%0d: got %h, expected %h", t, memAddrA[0],
                        own != 0 ? 32'h08 : 32'h04);
            end
         end
         if (t == 11) idleInputs();
      end
   endtask

   task automatic test_reset_midop();
      preload(6'h08, 32'h5A5A0001);
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (status(2) !== 6'b0_10_001) begin
         errors++;
         $display("[TB] FAIL midop_before: got %b, expected 010001", status(2));
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (status(2) !== 6'b0) begin
         errors++;
         $display("[TB] FAIL midop_async: got %b, expected 000000", status(2));
      end
      idleInputs();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 1) reset = 1'b0;
         checks++;
         if ({status(2), p1RdataA[2]} !== {6'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL midop_quiet_c%0d: got %b/%h, expected 000000/0", c, status(2), p1RdataA[2]);
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h08, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0C, 32'h00000077);
      for (int t = 1; t <= 8; t++) begin
         logic [5:0] exp;
         @(negedge clk);
         case (t)
            1, 2, 3: exp = 6'b0_01_001;
            4:       exp = 6'b0_01_101;
            6:       exp = 6'b1_10_001;
            7:       exp = 6'b0_10_011;
            default: exp = 6'b0;
         endcase
         checks++;
         if (status(2) !== exp) begin
            errors++;
            $display("[TB] FAIL midop_after_t%0d: got %b, expected %b", t, status(2), exp);
         end
         if (t == 4) begin
            checks++;
            if (p0RdataA[2] !== 32'h5A5A0001) begin
               errors++;
               $display("[TB] FAIL midop_rdata: got %h, expected 5a5a0001", p0RdataA[2]);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         end
         if (t == 7) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
   endtask

   task automatic test_drop_req();
      preload(6'h30, 32'hCAFEF00D);
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      checks++;
      if (status(1) !== 6'b0_01_001) begin
         errors++;
         $display("[TB] FAIL drop_c1: got %b, expected 001001", status(1));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h3F, 32'h0);
      @(negedge clk);
      checks++;
      if ({status(1), memAddrA[1]} !== {6'b0_01_001, 32'h30}) begin
         errors++;
         $display("[TB] FAIL drop_c2: got %b/%h, expected 001001/30", status(1), memAddrA[1]);
      end
      @(negedge clk);
      checks++;
      if ({status(1), p0RdataA[1]} !== {6'b0_01_101, 32'hCAFEF00D}) begin
         errors++;
         $display("[TB] FAIL drop_ready: got %b/%h, expected 001101/cafef00d", status(1), p0RdataA[1]);
      end
      for (int c = 4; c <= 7; c++) begin
         @(negedge clk);
         checks++;
         if ({status(1), p0RdataA[1]} !== {6'b0, 32'hCAFEF00D}) begin
            errors++;
            $display("[TB] FAIL drop_idle_c%0d: got %b/%h, expected 000000/cafef00d", c, status(1), p0RdataA[1]);
         end
      end
   endtask

   // Transaction-level reference: each accepted request occupies the memory from start+1 to done,
   // where done is start+2 for writes and start+RD_LAT+1 for reads; ties go to the other port.
   task automatic test_random();
      logic [31:0] refMem [NI][64];
      int          mStart[NI], mDone[NI];
      logic        mOwner[NI], mWe[NI], mLast[NI];
      logic [31:0] mAddr[NI], mWdata[NI], mRd0[NI], mRd1[NI];
      for (int a = 0; a < 64; a++) begin
         logic [31:0] d;
         d = $urandom;
         for (int k = 0; k < NI; k++) refMem[k][a] = d;
         preload(6'(a), d);
      end
      doReset();
      for (int k = 0; k < NI; k++) begin
         mStart[k] = -10; mDone[k] = -1; mOwner[k] = 1'b0; mWe[k] = 1'b0; mLast[k] = 1'b1;
         mAddr[k] = '0; mWdata[k] = '0; mRd0[k] = '0; mRd1[k] = '0;
      end
      for (int t = 0; t < 600; t++) begin
         for (int k = 0; k < NI; k++) begin
            logic       act;
            logic [5:0] exp;
            act = (t > mStart[k]) && (t <= mDone[k]);
            if (act && t == mDone[k] && !mWe[k]) begin
               if (mOwner[k]) mRd1[k] = refMem[k][mAddr[k][5:0]];
               else           mRd0[k] = refMem[k][mAddr[k][5:0]];
            end
            exp = {act && mWe[k] && (t == mStart[k] + 1),
                   act ? (mOwner[k] ? 2'b10 : 2'b01) : 2'b00,
                   act && (t == mDone[k]) && !mOwner[k],
                   act && (t == mDone[k]) && mOwner[k],
                   act};
            checks++;
            if (status(k) !== exp) begin
               errors++;
               $display("[TB] FAIL rand_status inst%0d t%0d: got %b, expected %b", k, t, status(k), exp);
            end
            checks++;
            if ({p0RdataA[k], p1RdataA[k]} !== {mRd0[k], mRd1[k]}) begin
               errors++;
               $display("[TB] FAIL rand_rdata inst%0d t%0d: got %h/%h, expected %h/%h",
                        k, t, p0RdataA[k], p1RdataA[k], mRd0[k], mRd1[k]);
            end
            checks++;
            if ({memAddrA[k], memWdataA[k]} !== {mAddr[k], mWdata[k]}) begin
               errors++;
               $display("[TB] FAIL rand_membus inst%0d t%0d: got %h/%h, expected %h/%h",
                        k, t, memAddrA[k], memWdataA[k], mAddr[k], mWdata[k]);
            end
            if (act && mWe[k] && t == mStart[k] + 1) refMem[k][mAddr[k][5:0]] = mWdata[k];
         end
         applyStimulus(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
         applyStimulus(1'b1, $urandom_range(0, 3) != 0, 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
         for (int k = 0; k < NI; k++) begin
            if (t > mDone[k] && (p0Req || p1Req)) begin
               mOwner[k] = (p0Req && p1Req) ? ~mLast[k] : p1Req;
               mLast[k]  = mOwner[k];
               mWe[k]    = mOwner[k] ? p1We    : p0We;
               mAddr[k]  = mOwner[k] ? p1Addr  : p0Addr;
               mWdata[k] = mOwner[k] ? p1Wdata : p0Wdata;
               mStart[k] = t;
               mDone[k]  = t + (mWe[k] ? 2 : k + 2);
            end
         end
         @(negedge clk);
      end
      idleInputs();
   endtask

   initial begin
      reset = 1'b1;
      preWe = 1'b0; preAddr = '0; preData = '0;
      idleInputs();
      @(negedge clk);
      test_reset();
      test_write_p0();
      test_read_p1();
      test_fairness();
      test_reset_midop();
      test_drop_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
